// File: rtl/decode_issue_ctrl_pkg.sv
// Shared decode types: instruction classes, queue entry layout and
// per-class register-usage / serialization helpers.
package decode_issue_ctrl_pkg;

    typedef logic [31:0] inst_t;
    typedef logic [63:0] u64;

    // RV64I base + CSR/system classes; NOP doubles as "illegal encoding".
    typedef enum logic [5:0] {
        NOP, LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LD, LBU, LHU, LWU,
        SB, SH, SW, SD,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ADDIW, SLLIW, SRLIW, SRAIW,
        ADDW, SUBW, SLLW, SRLW, SRAW,
        FENCE, ECALL, EBREAK, MRET,
        CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI
    } instruction_type;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_BLOCK
    } issue_state_e;

    typedef struct packed {
        inst_t inst;
        u64    pc;
    } queue_entry_t;

    // Ops that must run alone: wait for an empty pipe, then block until commit.
    function automatic logic is_serial(input instruction_type op);
        case (op)
            CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI, ECALL, MRET: is_serial = 1'b1;
            default: is_serial = 1'b0;
        endcase
    endfunction

    // rs1 is treated as live for everything except the no-source forms.
    function automatic logic uses_rs1(input instruction_type op);
        case (op)
            LUI, AUIPC, JAL, NOP: uses_rs1 = 1'b0;
            default: uses_rs1 = 1'b1;
        endcase
    endfunction

    // rs2 is only read by register-register ALU ops, stores and branches.
    function automatic logic uses_rs2(input instruction_type op);
        case (op)
            ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
            ADDW, SUBW, SLLW, SRLW, SRAW,
            SB, SH, SW, SD,
            BEQ, BNE, BLT, BGE, BLTU, BGEU: uses_rs2 = 1'b1;
            default: uses_rs2 = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch -> decode -> execute handshake bundle plus the hazard/serialization
// side-band signals. slave = the decode controller, master = its environment.
interface decode_issue_ctrl_if #(
    parameter int STALL_CNT_W = 32
);
    import decode_issue_ctrl_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    inst_t                  in_inst;
    u64                     in_pc;
    logic                   out_valid;
    logic                   out_ready;
    instruction_type        out_op;
    inst_t                  out_inst;
    u64                     out_pc;
    logic [4:0]             out_rs1;
    logic [4:0]             out_rs2;
    logic [4:0]             out_rd;
    logic                   ex_load_valid;
    logic [4:0]             ex_load_rd;
    logic                   pipe_empty;
    logic                   serial_done;
    logic                   flush;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        input  ex_load_valid, ex_load_rd, pipe_empty, serial_done, flush,
        output in_ready, out_valid, out_op, out_inst, out_pc,
        output out_rs1, out_rs2, out_rd, stall_cnt
    );

    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        output ex_load_valid, ex_load_rd, pipe_empty, serial_done, flush,
        input  in_ready, out_valid, out_op, out_inst, out_pc,
        input  out_rs1, out_rs2, out_rd, stall_cnt
    );

endinterface

// File: rtl/decode_issue_ctrl_parse.sv
// Opcode classifier: maps a 32-bit RV64I/Zicsr word to instruction_type.
// Anything not recognised classifies as NOP.
module parse_instruction
    import decode_issue_ctrl_pkg::*;
(
    input  inst_t           i_inst,
    output instruction_type o_op
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    // Decode tree keyed on opcode, then funct3/funct7
    always_comb begin
        o_op = NOP;
        case (w_opcode)
            7'b0110111: o_op = LUI;
            7'b0010111: o_op = AUIPC;
            7'b1101111: o_op = JAL;
            7'b1100111: if (w_funct3 == 3'b000) o_op = JALR;
            7'b0001111: o_op = FENCE;
            7'b1100011: begin
                case (w_funct3)
                    3'b000: o_op = BEQ;
                    3'b001: o_op = BNE;
                    3'b100: o_op = BLT;
                    3'b101: o_op = BGE;
                    3'b110: o_op = BLTU;
                    3'b111: o_op = BGEU;
                    default: o_op = NOP;
                endcase
            end
            7'b0000011: begin
                case (w_funct3)
                    3'b000: o_op = LB;
                    3'b001: o_op = LH;
                    3'b010: o_op = LW;
                    3'b011: o_op = LD;
                    3'b100: o_op = LBU;
                    3'b101: o_op = LHU;
                    3'b110: o_op = LWU;
                    default: o_op = NOP;
                endcase
            end
            7'b0100011: begin
                case (w_funct3)
                    3'b000: o_op = SB;
                    3'b001: o_op = SH;
                    3'b010: o_op = SW;
                    3'b011: o_op = SD;
                    default: o_op = NOP;
                endcase
            end
            7'b0010011: begin
                case (w_funct3)
                    3'b000: o_op = ADDI;
                    3'b010: o_op = SLTI;
                    3'b011: o_op = SLTIU;
                    3'b100: o_op = XORI;
                    3'b110: o_op = ORI;
                    3'b111: o_op = ANDI;
                    // RV64 shift amounts are 6 bits, so only inst[31:26] selects the form
                    3'b001: if (i_inst[31:26] == 6'b000000) o_op = SLLI;
                    3'b101: begin
                        if (i_inst[31:26] == 6'b000000)      o_op = SRLI;
                        else if (i_inst[31:26] == 6'b010000) o_op = SRAI;
                    end
                    default: o_op = NOP;
                endcase
            end
            7'b0110011: begin
                if (w_funct7 == 7'b0000000) begin
                    case (w_funct3)
                        3'b000: o_op = ADD;
                        3'b001: o_op = SLL;
                        3'b010: o_op = SLT;
                        3'b011: o_op = SLTU;
                        3'b100: o_op = XOR;
                        3'b101: o_op = SRL;
                        3'b110: o_op = OR;
                        3'b111: o_op = AND;
                        default: o_op = NOP;
                    endcase
                end else if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000)      o_op = SUB;
                    else if (w_funct3 == 3'b101) o_op = SRA;
                end
            end
            7'b0011011: begin
                if (w_funct3 == 3'b000) o_op = ADDIW;
                else if (w_funct3 == 3'b001 && w_funct7 == 7'b0000000) o_op = SLLIW;
                else if (w_funct3 == 3'b101 && w_funct7 == 7'b0000000) o_op = SRLIW;
                else if (w_funct3 == 3'b101 && w_funct7 == 7'b0100000) o_op = SRAIW;
            end
            7'b0111011: begin
                if (w_funct7 == 7'b0000000) begin
                    if (w_funct3 == 3'b000)      o_op = ADDW;
                    else if (w_funct3 == 3'b001) o_op = SLLW;
                    else if (w_funct3 == 3'b101) o_op = SRLW;
                end else if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000)      o_op = SUBW;
                    else if (w_funct3 == 3'b101) o_op = SRAW;
                end
            end
            7'b1110011: begin
                case (w_funct3)
                    3'b000: begin
                        if (i_inst == 32'h0000_0073)      o_op = ECALL;
                        else if (i_inst == 32'h0010_0073) o_op = EBREAK;
                        else if (i_inst == 32'h3020_0073) o_op = MRET;
                    end
                    3'b001: o_op = CSRRW;
                    3'b010: o_op = CSRRS;
                    3'b011: o_op = CSRRC;
                    3'b101: o_op = CSRRWI;
                    3'b110: o_op = CSRRSI;
                    3'b111: o_op = CSRRCI;
                    default: o_op = NOP;
                endcase
            end
            default: o_op = NOP;
        endcase
    end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-stage controller: 2-entry instruction queue, head classification,
// load-use interlock, CSR/ECALL/MRET serialization and flush handling.
module decode_issue_ctrl #(
    parameter int DEPTH       = 2,
    parameter int STALL_CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    decode_issue_ctrl_if.slave bus
);
    import decode_issue_ctrl_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    queue_entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    issue_state_e           r_state;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    queue_entry_t    w_head;
    instruction_type w_head_op;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic            w_not_empty;
    logic            w_in_ready;
    logic            w_enq;
    logic            w_deq;
    logic            w_hazard;
    logic            w_head_serial;
    logic            w_out_valid;

    // Head is read straight from the registered queue, so a word written this
    // cycle only becomes visible next cycle (no fetch->issue bypass).
    assign w_head      = r_mem[r_rd_ptr];
    assign w_rs1       = w_head.inst[19:15];
    assign w_rs2       = w_head.inst[24:20];
    assign w_rd        = w_head.inst[11:7];
    assign w_not_empty = (r_count != '0);
    assign w_in_ready  = (r_count < CNT_W'(DEPTH));
    assign w_enq       = bus.in_valid && w_in_ready;
    assign w_deq       = w_out_valid && bus.out_ready;

    parse_instruction u_parse (
        .i_inst (w_head.inst),
        .o_op   (w_head_op)
    );

    assign w_head_serial = is_serial(w_head_op);

    // x0 never carries a real dependency, so a load to x0 does not interlock.
    assign w_hazard = bus.ex_load_valid && (bus.ex_load_rd != 5'd0) &&
                      ((uses_rs1(w_head_op) && (w_rs1 == bus.ex_load_rd)) ||
                       (uses_rs2(w_head_op) && (w_rs2 == bus.ex_load_rd)));

    // Issue permission per FSM state
    always_comb begin
        w_out_valid = 1'b0;
        case (r_state)
            ST_RUN:   w_out_valid = w_not_empty && !w_hazard && !w_head_serial;
            ST_DRAIN: w_out_valid = w_not_empty && bus.pipe_empty;
            default:  w_out_valid = 1'b0;
        endcase
    end

    // Queue payload storage; writes dropped while a flush is in progress
    always_ff @(posedge clk) begin
        if (w_enq && !bus.flush) begin
            r_mem[r_wr_ptr] <= '{inst: bus.in_inst, pc: bus.in_pc};
        end
    end

    // Queue pointers, occupancy and RUN/DRAIN/BLOCK sequencing; flush wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_RUN;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_RUN;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
            case (r_state)
                ST_RUN:   if (w_not_empty && w_head_serial) r_state <= ST_DRAIN;
                ST_DRAIN: if (w_deq) r_state <= ST_BLOCK;
                ST_BLOCK: if (bus.serial_done) r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    // Saturating count of cycles where work is queued but nothing issues
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_not_empty && !w_out_valid && !bus.flush && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_op    = w_head_op;
    assign bus.out_inst  = w_head.inst;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_rs1   = w_rs1;
    assign bus.out_rs2   = w_rs2;
    assign bus.out_rd    = w_rd;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl. A second instance with a 2-bit stall
// counter shares the same stimulus to exercise saturation.
module tb_decode_issue_ctrl;
    import decode_issue_ctrl_pkg::*;

    localparam logic [31:0] I_ADD   = 32'h0020_81B3; // add  x3,x1,x2
    localparam logic [31:0] I_XOR   = 32'h0020_C1B3; // xor  x3,x1,x2
    localparam logic [31:0] I_SUB   = 32'h4020_81B3; // sub  x3,x1,x2
    localparam logic [31:0] I_LU    = 32'h0002_8333; // add  x6,x5,x0
    localparam logic [31:0] I_CSRRW = 32'h3050_1073; // csrrw x0,mtvec,x0
    localparam logic [31:0] I_MRET  = 32'h3020_0073;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    decode_issue_ctrl_if #(.STALL_CNT_W(32)) bus ();
    decode_issue_ctrl_if #(.STALL_CNT_W(2))  sbus ();

    decode_issue_ctrl #(.DEPTH(2), .STALL_CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    decode_issue_ctrl #(.DEPTH(2), .STALL_CNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus)
    );

    assign sbus.in_valid      = bus.in_valid;
    assign sbus.in_inst       = bus.in_inst;
    assign sbus.in_pc         = bus.in_pc;
    assign sbus.out_ready     = bus.out_ready;
    assign sbus.ex_load_valid = bus.ex_load_valid;
    assign sbus.ex_load_rd    = bus.ex_load_rd;
    assign sbus.pipe_empty    = bus.pipe_empty;
    assign sbus.serial_done   = bus.serial_done;
    assign sbus.flush         = bus.flush;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [63:0] pc);
        bus.in_valid = 1'b1;
        bus.in_inst  = inst;
        bus.in_pc    = pc;
    endtask

    initial begin
        reset             = 1'b1;
        bus.in_valid      = 1'b0;
        bus.in_inst       = '0;
        bus.in_pc         = '0;
        bus.out_ready     = 1'b0;
        bus.ex_load_valid = 1'b0;
        bus.ex_load_rd    = '0;
        bus.pipe_empty    = 1'b1;
        bus.serial_done   = 1'b0;
        bus.flush         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_stall_cnt", bus.stall_cnt, 0);
        reset = 1'b0;

        // Streaming: ADD then XOR, one per cycle after one fill cycle
        bus.out_ready = 1'b1;
        offer(I_ADD, 64'h1000); #1;
        check_eq("str_fill_ready", bus.in_ready, 1);
        check_eq("str_no_bypass", bus.out_valid, 0);
        tick();
        offer(I_XOR, 64'h1004); #1;
        check_eq("str0_valid", bus.out_valid, 1);
        check_eq("str0_op", bus.out_op, ADD);
        check_eq("str0_rd", bus.out_rd, 3);
        check_eq("str0_pc", bus.out_pc, 64'h1000);
        tick();
        bus.in_valid = 1'b0; #1;
        check_eq("str1_valid", bus.out_valid, 1);
        check_eq("str1_op", bus.out_op, XOR);
        check_eq("str1_rd", bus.out_rd, 3);
        check_eq("str1_pc", bus.out_pc, 64'h1004);
        tick(); #1;
        check_eq("str_empty", bus.out_valid, 0);
        check_eq("str_stall", bus.stall_cnt, 0);

        // Backpressure: 3 offered, only 2 fit
        bus.out_ready = 1'b0;
        offer(I_ADD, 64'h2000); #1;
        check_eq("bp_rdy0", bus.in_ready, 1);
        tick();
        offer(I_XOR, 64'h2004); #1;
        check_eq("bp_rdy1", bus.in_ready, 1);
        tick();
        offer(I_SUB, 64'h2008); #1;
        check_eq("bp_full", bus.in_ready, 0);
        check_eq("bp_head_pc", bus.out_pc, 64'h2000);
        tick(); #1;
        check_eq("bp_still_full", bus.in_ready, 0);
        bus.out_ready = 1'b1; #1;
        check_eq("bp_d0_op", bus.out_op, ADD);
        check_eq("bp_d0_pc", bus.out_pc, 64'h2000);
        tick(); #1;
        check_eq("bp_d1_op", bus.out_op, XOR);
        check_eq("bp_d1_pc", bus.out_pc, 64'h2004);
        tick();
        bus.in_valid = 1'b0; #1;
        check_eq("bp_d2_op", bus.out_op, SUB);
        check_eq("bp_d2_pc", bus.out_pc, 64'h2008);
        tick(); #1;
        check_eq("bp_empty", bus.out_valid, 0);

        // Load-use on rs1 = x5
        bus.out_ready     = 1'b0;
        bus.ex_load_valid = 1'b1;
        bus.ex_load_rd    = 5'd5;
        offer(I_LU, 64'h3000);
        tick();
        bus.in_valid = 1'b0; #1;
        check_eq("lu_stall", bus.out_valid, 0);
        tick(); #1;
        check_eq("lu_cnt1", bus.stall_cnt, 1);
        check_eq("lu_sat1", sbus.stall_cnt, 1);
        tick(); #1;
        check_eq("lu_cnt2", bus.stall_cnt, 2);
        check_eq("lu_sat2", sbus.stall_cnt, 2);
        bus.ex_load_rd = 5'd0; #1;
        check_eq("lu_x0_issue", bus.out_valid, 1);
        check_eq("lu_x0_rd", bus.out_rd, 6);
        bus.out_ready = 1'b1;
        tick(); #1;
        check_eq("lu_done", bus.out_valid, 0);
        check_eq("lu_cnt_hold", bus.stall_cnt, 2);
        bus.ex_load_valid = 1'b0;

        // Serialization: CSRRW waits for empty pipe, ADD waits for serial_done
        bus.pipe_empty = 1'b0;
        offer(I_CSRRW, 64'h4000);
        tick();
        offer(I_ADD, 64'h4004); #1;
        check_eq("ser_run_hold", bus.out_valid, 0);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.serial_done = (i == 1);   // must be ignored outside BLOCK
            #1;
            check_eq("ser_drain_hold", bus.out_valid, 0);
            tick();
        end
        bus.serial_done = 1'b0;
        bus.pipe_empty  = 1'b1; #1;
        check_eq("ser_issue", bus.out_valid, 1);
        check_eq("ser_op", bus.out_op, CSRRW);
        check_eq("ser_pc", bus.out_pc, 64'h4000);
        check_eq("ser_cnt", bus.stall_cnt, 6);
        tick(); #1;
        check_eq("ser_block", bus.out_valid, 0);
        tick();
        bus.serial_done = 1'b1; #1;
        check_eq("ser_block_done", bus.out_valid, 0);
        tick();
        bus.serial_done = 1'b0; #1;
        check_eq("ser_next_valid", bus.out_valid, 1);
        check_eq("ser_next_op", bus.out_op, ADD);
        check_eq("ser_next_pc", bus.out_pc, 64'h4004);
        check_eq("ser_next_cnt", bus.stall_cnt, 8);
        check_eq("ser_sat", sbus.stall_cnt, 3);
        tick(); #1;
        check_eq("ser_empty", bus.out_valid, 0);

        // MRET into BLOCK, then flush with a same-cycle enqueue
        offer(I_MRET, 64'h5000);
        tick();
        bus.in_valid = 1'b0; #1;
        check_eq("mret_hold", bus.out_valid, 0);
        tick(); #1;
        check_eq("mret_op", bus.out_op, MRET);
        check_eq("mret_issue", bus.out_valid, 1);
        tick();
        offer(I_ADD, 64'h5004);
        tick();
        offer(I_XOR, 64'h5008);
        bus.flush = 1'b1; #1;
        check_eq("fl_block_hold", bus.out_valid, 0);
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0; #1;
        check_eq("fl_empty", bus.out_valid, 0);
        check_eq("fl_in_ready", bus.in_ready, 1);
        check_eq("fl_cnt", bus.stall_cnt, 9);
        check_eq("fl_sat", sbus.stall_cnt, 3);
        offer(I_SUB, 64'h500C);
        tick();
        bus.in_valid = 1'b0; #1;
        check_eq("fl_run_valid", bus.out_valid, 1);
        check_eq("fl_run_pc", bus.out_pc, 64'h500C);
        check_eq("fl_run_op", bus.out_op, SUB);
        tick(); #1;
        check_eq("fl_no_ghost", bus.out_valid, 0);

        // Async reset while in DRAIN with two entries queued
        bus.out_ready = 1'b0;
        offer(I_CSRRW, 64'h6000);
        tick();
        offer(I_ADD, 64'h6004);
        tick();
        bus.in_valid = 1'b0; #1;
        check_eq("ar_pre_full", bus.in_ready, 0);
        check_eq("ar_pre_valid", bus.out_valid, 1);
        #2;
        reset = 1'b1; #1;
        check_eq("ar_out_valid", bus.out_valid, 0);
        check_eq("ar_in_ready", bus.in_ready, 1);
        check_eq("ar_stall", bus.stall_cnt, 0);
        check_eq("ar_sat", sbus.stall_cnt, 0);
        tick();
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
